// File: rtl/cipher_frame_pkg.sv
// Shared types and constants for the ciphertext framer.
package cipher_frame_pkg;

    typedef enum logic [2:0] {IDLE, HDR, LEN, PAY, CHK} frame_state_t;

    localparam logic [7:0] SOF_DEFAULT = 8'hA5;

endpackage

// File: rtl/byte_fifo.sv
// Byte FIFO with combinational head and an explicit occupancy counter.
// The caller qualifies push/pop; push while full is legal only with a same-cycle pop.
module byte_fifo #(
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [7:0]                 wdata,
    input  logic                       pop,
    output logic [7:0]                 rdata,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       full,
    output logic                       empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [LW-1:0] cnt_q,  cnt_d;

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q;
        // DEPTH is a power of two, so pointer overflow is the modulo wrap
        if (push) wptr_d = wptr_q + AW'(1);
        if (pop)  rptr_d = rptr_q + AW'(1);
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + LW'(1);
            2'b01:   cnt_d = cnt_q - LW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wptr_q] <= wdata;
    end

    assign rdata = mem_q[rptr_q];
    assign level = cnt_q;
    assign full  = (cnt_q == LW'(DEPTH));
    assign empty = (cnt_q == '0);

endmodule

// File: rtl/cipher_framer.sv
// Buffers an unstallable ciphertext byte stream and emits fixed-length frames:
// SOF, length, FRAME_LEN payload bytes, XOR checksum, on a ready/valid link.
module cipher_framer
    import cipher_frame_pkg::*;
#(
    parameter int         DEPTH     = 16,
    parameter int         FRAME_LEN = 8,
    parameter logic [7:0] SOF_BYTE  = SOF_DEFAULT
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [7:0]             din,
    input  logic                   v,
    output logic [7:0]             out_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   out_sof,
    output logic                   out_eof,
    output logic [$clog2(DEPTH):0] level,
    output logic                   overflow
);

    localparam int         LW       = $clog2(DEPTH) + 1;
    localparam logic [LW-1:0] FL_LVL = LW'(FRAME_LEN);
    localparam logic [7:0] FL_BYTE  = 8'(FRAME_LEN);
    localparam logic [7:0] FL_LAST  = 8'(FRAME_LEN - 1);

    frame_state_t state_q, state_d;
    logic [7:0]   cnt_q, cnt_d;
    logic [7:0]   csum_q, csum_d;
    logic         ovf_q, ovf_d;

    logic         push, pop;
    logic [7:0]   head;
    logic         fifo_full, fifo_empty;

    // Popping only happens on a PAY transfer; a pop frees the slot a full-FIFO push needs
    assign pop  = (state_q == PAY) && out_ready && !fifo_empty;
    assign push = v && (!fifo_full || pop);

    byte_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .wdata (din),
        .pop   (pop),
        .rdata (head),
        .level (level),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        csum_d    = csum_q;
        ovf_d     = ovf_q | (v && fifo_full && !pop);
        out_valid = 1'b0;
        out_data  = 8'h00;
        out_sof   = 1'b0;
        out_eof   = 1'b0;
        case (state_q)
            IDLE: begin
                // Only a whole frame's worth of bytes starts a frame, so PAY never underruns
                if (level >= FL_LVL) state_d = HDR;
            end
            HDR: begin
                out_valid = 1'b1;
                out_data  = SOF_BYTE;
                out_sof   = 1'b1;
                if (out_ready) state_d = LEN;
            end
            LEN: begin
                out_valid = 1'b1;
                out_data  = FL_BYTE;
                if (out_ready) begin
                    state_d = PAY;
                    cnt_d   = 8'h00;
                    csum_d  = 8'h00;
                end
            end
            PAY: begin
                out_valid = 1'b1;
                out_data  = head;
                if (out_ready) begin
                    csum_d = csum_q ^ head;
                    cnt_d  = cnt_q + 8'h01;
                    if (cnt_q == FL_LAST) state_d = CHK;
                end
            end
            CHK: begin
                out_valid = 1'b1;
                out_data  = csum_q;
                out_eof   = 1'b1;
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 8'h00;
            csum_q  <= 8'h00;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            csum_q  <= csum_d;
            ovf_q   <= ovf_d;
        end
    end

    assign overflow = ovf_q;

endmodule

// File: tb/tb_cipher_framer.sv
// Directed bench for cipher_framer (DEPTH=16, FRAME_LEN=4) with hand-computed frames.
module tb_cipher_framer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] din = 8'h00;
    logic       v = 1'b0;
    logic       out_ready = 1'b0;
    logic [7:0] out_data;
    logic       out_valid, out_sof, out_eof, overflow;
    logic [4:0] level;

    int n_cmp = 0;
    int n_bad = 0;

    logic [9:0] cap[$];
    logic [9:0] exp_q[$];

    logic       stalled = 1'b0;
    logic [7:0] h_data;
    logic [1:0] h_flags;

    cipher_framer #(.DEPTH(16), .FRAME_LEN(4), .SOF_BYTE(8'hA5)) dut (
        .clk       (clk),
        .rst       (rst),
        .din       (din),
        .v         (v),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sof   (out_sof),
        .out_eof   (out_eof),
        .level     (level),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Capture transfers and verify outputs hold across stall cycles
    always @(negedge clk) begin
        if (rst) begin
            stalled = 1'b0;
        end else begin
            if (stalled) begin
                chk("hold_data", {24'h0, out_data}, {24'h0, h_data});
                chk("hold_flags", {30'h0, out_sof, out_eof}, {30'h0, h_flags});
            end
            stalled = out_valid && !out_ready;
            h_data  = out_data;
            h_flags = {out_sof, out_eof};
            if (out_valid && out_ready) cap.push_back({out_sof, out_eof, out_data});
        end
    end

    task automatic step(input logic vv, input logic [7:0] d, input logic r);
        v = vv;
        din = d;
        out_ready = r;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_cap(input int n, input int budget);
        int k = 0;
        while (cap.size() < n && k < budget) begin
            step(1'b0, 8'h00, 1'b1);
            k++;
        end
        if (cap.size() < n) chk("timeout", cap.size(), n);
    endtask

    task automatic add_frame(input logic [31:0] p, input logic [7:0] cs);
        exp_q.push_back(10'h2A5);
        exp_q.push_back(10'h004);
        for (int i = 3; i >= 0; i--) exp_q.push_back({2'b00, p[i*8 +: 8]});
        exp_q.push_back({2'b01, cs});
    endtask

    task automatic cmp_frames(input string tag);
        chk({tag, "_len"}, cap.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++)
            if (i < cap.size()) chk(tag, {22'h0, cap[i]}, {22'h0, exp_q[i]});
        cap.delete();
        exp_q.delete();
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        step(1'b0, 8'h00, 1'b0);
        step(1'b0, 8'h00, 1'b0);
        rst = 1'b0;
        cap.delete();
    endtask

    initial begin
        // reset values
        step(1'b0, 8'h00, 1'b0);
        step(1'b0, 8'h00, 1'b0);
        chk("rst_valid", out_valid, 0);
        chk("rst_data", out_data, 0);
        chk("rst_sof_eof", {out_sof, out_eof}, 0);
        chk("rst_level", level, 0);
        chk("rst_ovf", overflow, 0);
        rst = 1'b0;
        step(1'b0, 8'h00, 1'b1);

        // basic frame and latency
        step(1'b1, 8'h11, 1'b1);
        step(1'b1, 8'h22, 1'b1);
        step(1'b1, 8'h33, 1'b1);
        step(1'b1, 8'h44, 1'b1);
        chk("lat_level", level, 4);
        chk("lat_novalid", out_valid, 0);
        step(1'b0, 8'h00, 1'b1);
        chk("lat_valid", out_valid, 1);
        chk("lat_sof", {out_sof, out_data}, 9'h1A5);
        wait_cap(7, 30);
        add_frame(32'h11223344, 8'h44);
        cmp_frames("f1");
        step(1'b0, 8'h00, 1'b1);
        step(1'b0, 8'h00, 1'b1);

        // backpressure pattern 1,0,0 repeating
        for (int i = 0; i < 60 && cap.size() < 7; i++) begin
            if (i < 4) step(1'b1, 8'h11 * (i + 1), (i % 3) == 0);
            else       step(1'b0, 8'h00, (i % 3) == 0);
        end
        add_frame(32'h11223344, 8'h44);
        cmp_frames("f2_stall");
        step(1'b0, 8'h00, 1'b1);
        step(1'b0, 8'h00, 1'b1);

        // partial frame must not start
        step(1'b1, 8'h01, 1'b1);
        step(1'b1, 8'h02, 1'b1);
        step(1'b1, 8'h03, 1'b1);
        for (int i = 0; i < 5; i++) step(1'b0, 8'h00, 1'b1);
        chk("part_valid", out_valid, 0);
        chk("part_level", level, 3);
        chk("part_nocap", cap.size(), 0);
        step(1'b1, 8'h04, 1'b1);
        wait_cap(7, 30);
        add_frame(32'h01020304, 8'h04);
        cmp_frames("f3");

        // overflow: 17 bytes into a stalled 16-deep FIFO
        pulse_reset();
        for (int i = 0; i < 17; i++) step(1'b1, 8'(i), 1'b0);
        chk("ovf_level", level, 16);
        chk("ovf_flag", overflow, 1);
        wait_cap(28, 80);
        add_frame(32'h00010203, 8'h00);
        add_frame(32'h04050607, 8'h00);
        add_frame(32'h08090A0B, 8'h00);
        add_frame(32'h0C0D0E0F, 8'h00);
        cmp_frames("f4_ovf");
        step(1'b0, 8'h00, 1'b1);
        chk("ovf_sticky", overflow, 1);
        chk("ovf_drained", level, 0);

        // push into full FIFO during a payload transfer
        pulse_reset();
        for (int i = 0; i < 16; i++) step(1'b1, 8'(i), 1'b0);
        chk("full_level", level, 16);
        chk("full_ovf0", overflow, 0);
        step(1'b0, 8'h00, 1'b1);
        step(1'b0, 8'h00, 1'b1);
        step(1'b1, 8'h20, 1'b1);
        chk("pp_level", level, 16);
        chk("pp_ovf", overflow, 0);
        wait_cap(28, 80);
        add_frame(32'h00010203, 8'h00);
        add_frame(32'h04050607, 8'h00);
        add_frame(32'h08090A0B, 8'h00);
        add_frame(32'h0C0D0E0F, 8'h00);
        cmp_frames("f5");
        step(1'b0, 8'h00, 1'b1);
        chk("pp_left", level, 1);

        // asynchronous reset mid-payload
        pulse_reset();
        step(1'b1, 8'h11, 1'b1);
        step(1'b1, 8'h22, 1'b1);
        step(1'b1, 8'h33, 1'b1);
        step(1'b1, 8'h44, 1'b1);
        wait_cap(4, 20);
        rst = 1'b1;
        #1;
        chk("arst_valid", out_valid, 0);
        chk("arst_level", level, 0);
        chk("arst_data", out_data, 0);
        step(1'b0, 8'h00, 1'b1);
        step(1'b0, 8'h00, 1'b1);
        rst = 1'b0;
        cap.delete();
        step(1'b1, 8'hA1, 1'b1);
        step(1'b1, 8'hB2, 1'b1);
        step(1'b1, 8'hC3, 1'b1);
        step(1'b1, 8'hD4, 1'b1);
        wait_cap(7, 30);
        add_frame(32'hA1B2C3D4, 8'h04);
        cmp_frames("f6_after_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
